// File: rtl/afe_ctrl.sv
// AFE control sequencer: powers the analog front end up, then executes SPI write/read,
// static control and delay commands popped from the CPU command FIFO one at a time.
module afe_ctrl #(
    parameter int CLK_DIV      = 4,
    parameter int RESET_CYCLES = 16,
    parameter int WAIT_CYCLES  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cmd_data,
    input  logic        cmd_empty,
    output logic        cmd_rd,
    output logic [7:0]  rsp_data,
    output logic        rsp_valid,
    output logic        afe_reset,
    output logic        spi_clk,
    output logic        spi_mosi,
    output logic        spi_sen,
    input  logic        spi_miso,
    output logic        tx_en,
    output logic        rx_en,
    output logic        loopback,
    output logic        ready
);

    localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [RW-1:0] RST_LAST  = RW'(RESET_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYCLES - 1);
    localparam logic [7:0]    DIV_LAST  = 8'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        RST_ASSERT, RST_WAIT, IDLE, FETCH, DECODE,
        SPI_SETUP, SPI_SHIFT, SPI_HOLD, SPI_GAP, DELAY
    } state_t;

    state_t        state;
    logic [RW-1:0] rst_cnt;
    logic [WW-1:0] wait_cnt;
    logic [7:0]    div_cnt;
    logic [4:0]    bit_cnt;
    logic [15:0]   dly_cnt;
    logic [31:0]   cmd;
    logic [23:0]   tx_sr;
    logic [7:0]    rx_sr;
    logic          is_read;
    logic [23:0]   frame;
    logic          div_done;
    logic          unused_cmd;

    // The FIFO read strobe must sit in the same cycle IDLE sees a non-empty FIFO.
    assign cmd_rd     = (state == IDLE) && !cmd_empty;
    assign div_done   = (div_cnt == DIV_LAST);
    assign unused_cmd = cmd[29];

    // Read frames drive zeros on the data byte so the AFE can return its register.
    always_comb begin
        frame = {cmd[31:30] == 2'b01, 2'b00, cmd[28:16],
                 (cmd[31:30] == 2'b01) ? 8'h00 : cmd[7:0]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RST_ASSERT;
            rst_cnt   <= '0;
            wait_cnt  <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            dly_cnt   <= '0;
            cmd       <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            is_read   <= 1'b0;
            afe_reset <= 1'b1;
            spi_sen   <= 1'b1;
            spi_clk   <= 1'b0;
            spi_mosi  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            tx_en     <= 1'b0;
            rx_en     <= 1'b0;
            loopback  <= 1'b0;
            ready     <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                RST_ASSERT: begin
                    if (rst_cnt == RST_LAST) begin
                        rst_cnt   <= '0;
                        afe_reset <= 1'b0;
                        state     <= RST_WAIT;
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                RST_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        wait_cnt <= '0;
                        ready    <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (!cmd_empty) begin
                        ready <= 1'b0;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    cmd   <= cmd_data;
                    state <= DECODE;
                end
                DECODE: begin
                    case (cmd[31:30])
                        2'b00, 2'b01: begin
                            spi_sen  <= 1'b0;
                            spi_clk  <= 1'b0;
                            spi_mosi <= frame[23];
                            tx_sr    <= {frame[22:0], 1'b0};
                            is_read  <= cmd[30];
                            div_cnt  <= '0;
                            bit_cnt  <= '0;
                            state    <= SPI_SETUP;
                        end
                        2'b10: begin
                            if (cmd[8]) begin
                                tx_en     <= 1'b0;
                                rx_en     <= 1'b0;
                                loopback  <= cmd[2];
                                afe_reset <= 1'b1;
                                rst_cnt   <= '0;
                                state     <= RST_ASSERT;
                            end else begin
                                {loopback, rx_en, tx_en} <= cmd[2:0];
                                ready <= 1'b1;
                                state <= IDLE;
                            end
                        end
                        default: begin
                            if (cmd[15:0] == 16'd0) begin
                                ready <= 1'b1;
                                state <= IDLE;
                            end else begin
                                dly_cnt <= cmd[15:0];
                                state   <= DELAY;
                            end
                        end
                    endcase
                end
                SPI_SETUP: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        state   <= SPI_SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SPI_SHIFT: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        if (!spi_clk) begin
                            spi_clk <= 1'b1;
                            rx_sr   <= {rx_sr[6:0], spi_miso};
                        end else begin
                            spi_clk <= 1'b0;
                            if (bit_cnt == 5'd23) begin
                                bit_cnt <= '0;
                                state   <= SPI_HOLD;
                            end else begin
                                bit_cnt  <= bit_cnt + 1'b1;
                                spi_mosi <= tx_sr[23];
                                tx_sr    <= {tx_sr[22:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SPI_HOLD: begin
                    if (div_done) begin
                        div_cnt   <= '0;
                        spi_sen   <= 1'b1;
                        spi_mosi  <= 1'b0;
                        rsp_valid <= is_read;
                        if (is_read) rsp_data <= rx_sr;
                        state     <= SPI_GAP;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SPI_GAP: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        ready   <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DELAY: begin
                    if (dly_cnt == 16'd1) begin
                        ready <= 1'b1;
                        state <= IDLE;
                    end else begin
                        dly_cnt <= dly_cnt - 1'b1;
                    end
                end
                default: state <= RST_ASSERT;
            endcase
        end
    end

endmodule

// File: tb/tb_afe_ctrl.sv
// Randomized bench for afe_ctrl: a FIFO model feeds commands and a per-command
// reference derives frame contents, busy time and control state from the command rules.
module tb_afe_ctrl;

    localparam int H  = 4;
    localparam int RC = 16;
    localparam int WC = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cmd_data = '0;
    logic        cmd_empty = 1'b1;
    logic        cmd_rd;
    logic [7:0]  rsp_data;
    logic        rsp_valid;
    logic        afe_reset;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_sen;
    logic        spi_miso = 1'b0;
    logic        tx_en;
    logic        rx_en;
    logic        loopback;
    logic        ready;

    afe_ctrl #(.CLK_DIV(H), .RESET_CYCLES(RC), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset(reset), .cmd_data(cmd_data), .cmd_empty(cmd_empty),
        .cmd_rd(cmd_rd), .rsp_data(rsp_data), .rsp_valid(rsp_valid),
        .afe_reset(afe_reset), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .spi_sen(spi_sen), .spi_miso(spi_miso), .tx_en(tx_en), .rx_en(rx_en),
        .loopback(loopback), .ready(ready)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          push_total = 0;
    int          rd_total = 0;
    logic        rd_pend = 1'b0;
    logic [31:0] fifo_q[$];
    logic        exp_tx = 1'b0, exp_rx = 1'b0, exp_lb = 1'b0;

    // Command FIFO model: the pop seen mid-cycle takes effect at the next rising edge.
    always @(negedge clk) begin
        rd_pend <= cmd_rd;
        if (cmd_rd === 1'b1) rd_total++;
    end

    always @(posedge clk) begin
        int sz;
        sz = fifo_q.size();
        if (rd_pend && sz > 0) begin
            cmd_data <= fifo_q.pop_front();
            sz--;
        end
        cmd_empty <= (sz == 0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] c);
        fifo_q.push_back(c);
        push_total++;
    endtask

    function automatic logic [23:0] exp_frame(input logic [31:0] c);
        logic rd;
        rd = (c[31:30] == 2'b01);
        return {rd, 2'b00, c[28:16], rd ? 8'h00 : c[7:0]};
    endfunction

    // Cycles from the cmd_rd cycle until ready is seen high again.
    function automatic int exp_busy(input logic [31:0] c);
        case (c[31:30])
            2'b00, 2'b01: return 3 + 50 * H + H;
            2'b10:        return c[8] ? 3 + RC + WC : 3;
            default:      return 3 + int'(c[15:0]);
        endcase
    endfunction

    // Called right after reset has been released at a falling edge.
    task automatic power_up(input string tag);
        int fall_k = -1;
        int rdy_k = -1;
        bit bad = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (ready === 1'b1) begin
                rdy_k = k;
                break;
            end
            if (afe_reset === 1'b0 && fall_k < 0) fall_k = k;
            if (spi_sen !== 1'b1 || spi_clk !== 1'b0 || spi_mosi !== 1'b0 || rsp_valid !== 1'b0 ||
                cmd_rd !== 1'b0 || tx_en !== 1'b0 || rx_en !== 1'b0 || loopback !== exp_lb)
                bad = 1'b1;
        end
        check({tag, "_afe_fall"}, 32'(fall_k), 32'(RC));
        check({tag, "_ready_rise"}, 32'(rdy_k), 32'(RC + WC));
        check({tag, "_quiet"}, 32'(bad), 32'd0);
    endtask

    task automatic observe_cmd(input string tag, input logic [31:0] c, input logic [7:0] mb);
        logic [15:0] hi_bits;
        logic [23:0] mw, mosi_w;
        logic [7:0]  rv_data;
        logic [1:0]  op;
        logic        prev_clk, prev_mosi, spi_op, rd_op;
        int t, busy, sen_first, sen_low, rises, rv_cnt, rv_k, rd_extra, afe_hi, rdy_k;
        bit mosi_bad;
        hi_bits = 16'($urandom);
        mw = {hi_bits, mb};
        mosi_w = '0; rv_data = '0; prev_clk = 1'b0; prev_mosi = 1'b0; mosi_bad = 1'b0;
        sen_first = -1; sen_low = 0; rises = 0; rv_cnt = 0; rv_k = -1;
        rd_extra = 0; afe_hi = 0; rdy_k = -1; t = 0;
        op = c[31:30];
        spi_op = (op == 2'b00) || (op == 2'b01);
        rd_op = (op == 2'b01);
        busy = exp_busy(c);
        while (cmd_rd !== 1'b1 && t < 2000) begin
            step();
            t++;
        end
        check({tag, "_cmd_rd"}, 32'(cmd_rd), 32'd1);
        spi_miso = mw[23];
        for (int k = 1; k <= busy + 50; k++) begin
            step();
            if (ready === 1'b1) begin
                rdy_k = k;
                break;
            end
            if (cmd_rd === 1'b1) rd_extra++;
            if (afe_reset === 1'b1) afe_hi++;
            if (spi_sen === 1'b0) begin
                sen_low++;
                if (sen_first < 0) sen_first = k;
            end else if (spi_mosi !== 1'b0) begin
                mosi_bad = 1'b1;
            end
            if (spi_clk === 1'b1 && prev_clk === 1'b1 && spi_mosi !== prev_mosi) mosi_bad = 1'b1;
            if (spi_clk === 1'b1 && prev_clk === 1'b0) begin
                mosi_w = {mosi_w[22:0], spi_mosi};
                rises++;
                spi_miso = (rises < 24) ? mw[23 - rises] : 1'b0;
            end
            prev_clk = spi_clk;
            prev_mosi = spi_mosi;
            if (rsp_valid === 1'b1) begin
                rv_cnt++;
                rv_k = k;
                rv_data = rsp_data;
            end
        end
        spi_miso = 1'b0;
        if (op == 2'b10) begin
            if (c[8]) {exp_lb, exp_rx, exp_tx} = {c[2], 2'b00};
            else      {exp_lb, exp_rx, exp_tx} = c[2:0];
        end
        check({tag, "_ready_ret"}, 32'(rdy_k), 32'(busy));
        check({tag, "_extra_rd"}, 32'(rd_extra), 32'd0);
        check({tag, "_ctrl"}, {29'd0, loopback, rx_en, tx_en}, {29'd0, exp_lb, exp_rx, exp_tx});
        check({tag, "_sen_low"}, 32'(sen_low), spi_op ? 32'(50 * H) : 32'd0);
        check({tag, "_rsp_cnt"}, 32'(rv_cnt), rd_op ? 32'd1 : 32'd0);
        check({tag, "_afe_hi"}, 32'(afe_hi), (op == 2'b10 && c[8]) ? 32'(RC) : 32'd0);
        if (spi_op) begin
            check({tag, "_sen_fall"}, 32'(sen_first), 32'd3);
            check({tag, "_rises"}, 32'(rises), 32'd24);
            check({tag, "_mosi"}, {8'd0, mosi_w}, {8'd0, exp_frame(c)});
            check({tag, "_mosi_clean"}, 32'(mosi_bad), 32'd0);
        end
        if (rd_op) begin
            check({tag, "_rsp_data"}, {24'd0, rv_data}, {24'd0, mb});
            check({tag, "_rsp_when"}, 32'(rv_k), 32'(3 + 50 * H));
        end
    endtask

    initial begin
        logic [31:0] c, bc[3];
        logic [7:0]  bm[3];
        int n, t, rises;
        logic prev_clk;

        repeat (3) step();
        check("rst_outs", {22'd0, afe_reset, spi_sen, spi_clk, spi_mosi, cmd_rd, rsp_valid,
                           tx_en, rx_en, loopback, ready}, 32'b11_0000_0000);
        check("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
        reset = 1'b0;
        power_up("pwr");

        push(32'h0012_00A5);
        observe_cmd("write", 32'h0012_00A5, 8'h00);
        push(32'h4003_0000);
        observe_cmd("read", 32'h4003_0000, 8'h5C);
        push(32'h8000_0007);
        observe_cmd("ctrl7", 32'h8000_0007, 8'h00);
        push(32'h8000_0104);
        observe_cmd("ctrl_rst", 32'h8000_0104, 8'h00);
        push(32'hC000_0000);
        push(32'hC000_000A);
        observe_cmd("dly0", 32'hC000_0000, 8'h00);
        observe_cmd("dly10", 32'hC000_000A, 8'h00);

        for (int b = 0; b < 6; b++) begin
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++) begin
                c = $urandom;
                c[31:30] = 2'($urandom_range(0, 3));
                if (c[31:30] == 2'b10) c[8] = ($urandom_range(0, 3) == 0);
                if (c[31:30] == 2'b11) c[15:0] = 16'($urandom_range(0, 40));
                bc[i] = c;
                bm[i] = 8'($urandom);
                push(c);
            end
            for (int i = 0; i < n; i++) observe_cmd("rand", bc[i], bm[i]);
        end

        // Asynchronous reset in the middle of a write frame, with a command waiting.
        push(32'h0155_5A3C);
        t = 0;
        while (cmd_rd !== 1'b1 && t < 2000) begin
            step();
            t++;
        end
        check("mid_cmd_rd", 32'(cmd_rd), 32'd1);
        push(32'hC000_0005);
        rises = 0;
        prev_clk = 1'b0;
        t = 0;
        while (rises < 10 && t < 1000) begin
            step();
            if (spi_clk === 1'b1 && prev_clk === 1'b0) rises++;
            prev_clk = spi_clk;
            t++;
        end
        check("mid_rises", 32'(rises), 32'd10);
        reset = 1'b1;
        step();
        check("mid_rst_outs", {26'd0, spi_sen, spi_clk, rsp_valid, cmd_rd, afe_reset, ready},
              32'b10_0010);
        repeat (3) step();
        reset = 1'b0;
        {exp_lb, exp_rx, exp_tx} = 3'b000;
        power_up("pwr2");
        observe_cmd("after_rst", 32'hC000_0005, 8'h00);

        repeat (5) step();
        check("rd_per_cmd", 32'(rd_total), 32'(push_total));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
